// File: rtl/coproc_pkg.sv
// Shared opcodes, FSM state encoding and default geometry for the coprocessor
// command sequencer and its datapath.
package coproc_pkg;

  localparam int N_VEC_DEF = 1024;
  localparam int AW_DEF    = 10;

  localparam logic [7:0] CMD_WRITE_A = 8'h01;
  localparam logic [7:0] CMD_WRITE_B = 8'h02;
  localparam logic [7:0] CMD_READ_A  = 8'h03;
  localparam logic [7:0] CMD_READ_B  = 8'h04;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WRITE     = 3'd1,
    RD_ADDR   = 3'd2,
    RD_WAIT   = 3'd3,
    RD_SEND   = 3'd4,
    RD_GUARD  = 3'd5,
    RD_TXWAIT = 3'd6
  } state_t;

  function automatic logic is_write_op(input logic [7:0] op);
    return (op == CMD_WRITE_A) || (op == CMD_WRITE_B);
  endfunction

  function automatic logic is_read_op(input logic [7:0] op);
    return (op == CMD_READ_A) || (op == CMD_READ_B);
  endfunction

endpackage

// File: rtl/seq_timeout_ctr.sv
// Idle-cycle watchdog: counts enabled cycles since the last clear and flags
// expiry once LIMIT cycles have elapsed. Saturates so expiry stays asserted
// until the owner clears it.
module seq_timeout_ctr #(
  parameter int LIMIT = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_CNT = CW'(LIMIT);

  logic [CW-1:0] r_cnt;

  // Idle counter: clear has priority, then count up to LIMIT and hold there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != LIMIT_CNT)) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_expired = (r_cnt == LIMIT_CNT);

endmodule

// File: rtl/coproc_cmd_sequencer.sv
// Command sequencer for the vector coprocessor: decodes opcodes from the UART
// receiver, streams payload bytes into vector BRAM A/B, and streams stored
// vectors back out through the UART transmitter.
module coproc_cmd_sequencer
  import coproc_pkg::*;
#(
  parameter int N_VEC   = N_VEC_DEF,
  parameter int AW      = AW_DEF,
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 1000000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    rx_data,
  input  logic          rx_ready,
  output logic [7:0]    tx_data,
  output logic          tx_start,
  input  logic          tx_busy,
  output logic [AW-1:0] addr,
  output logic [7:0]    din,
  output logic          wea_A,
  output logic          wea_B,
  input  logic [7:0]    dout_A,
  input  logic [7:0]    dout_B,
  output logic [7:0]    cur_op,
  output logic          busy,
  output logic          op_done,
  output logic          cmd_err
);

  // Counter is one bit wider than the address so N_VEC = 2**AW is reachable
  // without wrapping; completion is a plain compare.
  localparam logic [AW:0] LAST_IDX = (AW+1)'(N_VEC - 1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(N_VEC);
  // addr is registered, so the BRAM sees it one cycle after RD_ADDR; data is
  // therefore sampled RD_LAT cycles after that, i.e. after RD_LAT+1 wait cycles.
  localparam logic [1:0]  WAIT_END = 2'(RD_LAT);

  state_t        r_state;
  logic [AW:0]   r_cnt;
  logic [1:0]    r_wait;
  logic [7:0]    r_tx_data;
  logic          r_tx_start;
  logic [AW-1:0] r_addr;
  logic [7:0]    r_din;
  logic          r_wea_a;
  logic          r_wea_b;
  logic [7:0]    r_cur_op;
  logic          r_busy;
  logic          r_op_done;
  logic          r_cmd_err;

  logic w_tmo_clear;
  logic w_tmo_enable;
  logic w_tmo_expired;

  // The watchdog only runs while waiting for payload; every byte restarts it.
  assign w_tmo_clear  = (r_state != WRITE) || rx_ready;
  assign w_tmo_enable = (r_state == WRITE);

  seq_timeout_ctr #(
    .LIMIT(TIMEOUT)
  ) u_tmo (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_tmo_clear),
    .i_enable (w_tmo_enable),
    .o_expired(w_tmo_expired)
  );

  // Main sequencer FSM with all outputs registered; pulses default low each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_wait     <= 2'd0;
      r_tx_data  <= 8'h00;
      r_tx_start <= 1'b0;
      r_addr     <= '0;
      r_din      <= 8'h00;
      r_wea_a    <= 1'b0;
      r_wea_b    <= 1'b0;
      r_cur_op   <= 8'h00;
      r_busy     <= 1'b0;
      r_op_done  <= 1'b0;
      r_cmd_err  <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      r_wea_a    <= 1'b0;
      r_wea_b    <= 1'b0;
      r_op_done  <= 1'b0;
      r_cmd_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (rx_ready) begin
            if (is_write_op(rx_data)) begin
              r_state  <= WRITE;
              r_cur_op <= rx_data;
              r_cnt    <= '0;
              r_busy   <= 1'b1;
            end else if (is_read_op(rx_data)) begin
              r_state  <= RD_ADDR;
              r_cur_op <= rx_data;
              r_cnt    <= '0;
              r_busy   <= 1'b1;
            end else begin
              r_cmd_err <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (r_cnt == FULL_CNT) begin
            // Last element's wea is on the bus this cycle; finish next.
            r_op_done <= 1'b1;
            r_cur_op  <= 8'h00;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end else if (rx_ready) begin
            r_din  <= rx_data;
            r_addr <= r_cnt[AW-1:0];
            if (r_cur_op == CMD_WRITE_B) begin
              r_wea_b <= 1'b1;
            end else begin
              r_wea_a <= 1'b1;
            end
            r_cnt <= r_cnt + (AW+1)'(1);
          end else if (w_tmo_expired) begin
            // Abandon the partial vector; next command restarts at element 0.
            r_cmd_err <= 1'b1;
            r_cur_op  <= 8'h00;
            r_busy    <= 1'b0;
            r_cnt     <= '0;
            r_state   <= IDLE;
          end
        end
        RD_ADDR: begin
          r_addr  <= r_cnt[AW-1:0];
          r_wait  <= 2'd0;
          r_state <= RD_WAIT;
        end
        RD_WAIT: begin
          if (r_wait == WAIT_END) begin
            r_tx_data <= (r_cur_op == CMD_READ_B) ? dout_B : dout_A;
            r_state   <= RD_SEND;
          end else begin
            r_wait <= r_wait + 2'd1;
          end
        end
        RD_SEND: begin
          if (!tx_busy) begin
            r_tx_start <= 1'b1;
            r_state    <= RD_GUARD;
          end
        end
        RD_GUARD: begin
          // uart_tx raises busy one cycle after tx_start; skip that cycle.
          r_state <= RD_TXWAIT;
        end
        RD_TXWAIT: begin
          if (!tx_busy) begin
            if (r_cnt < LAST_IDX) begin
              r_cnt   <= r_cnt + (AW+1)'(1);
              r_state <= RD_ADDR;
            end else begin
              r_op_done <= 1'b1;
              r_cur_op  <= 8'h00;
              r_busy    <= 1'b0;
              r_state   <= IDLE;
            end
          end
        end
        default: begin
          r_state  <= IDLE;
          r_cur_op <= 8'h00;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_start = r_tx_start;
  assign addr     = r_addr;
  assign din      = r_din;
  assign wea_A    = r_wea_a;
  assign wea_B    = r_wea_b;
  assign cur_op   = r_cur_op;
  assign busy     = r_busy;
  assign op_done  = r_op_done;
  assign cmd_err  = r_cmd_err;

endmodule

// File: tb/tb_coproc_cmd_sequencer.sv
// Scoreboard bench for coproc_cmd_sequencer. Three copies with RD_LAT=1,2,3
// share the UART rx stimulus; each has its own BRAM and uart_tx model.
module tb_coproc_cmd_sequencer;

  localparam int N_VEC = 1024;
  localparam int AW    = 10;
  localparam int TMO   = 100;
  localparam int NI    = 3;
  localparam int WRW   = 1 + AW + 8;

  localparam logic [7:0] OP_WA = 8'h01;
  localparam logic [7:0] OP_WB = 8'h02;
  localparam logic [7:0] OP_RA = 8'h03;
  localparam logic [7:0] OP_RB = 8'h04;

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] rx_data;
  logic rx_ready;

  logic [NI-1:0][7:0]    tx_data, din, dout_A, dout_B, cur_op;
  logic [NI-1:0][AW-1:0] addr;
  logic [NI-1:0]         tx_start, tx_busy, wea_A, wea_B, busy, op_done, cmd_err;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    coproc_cmd_sequencer #(
      .N_VEC(N_VEC), .AW(AW), .RD_LAT(g + 1), .TIMEOUT(TMO)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_ready(rx_ready),
      .tx_data(tx_data[g]), .tx_start(tx_start[g]), .tx_busy(tx_busy[g]),
      .addr(addr[g]), .din(din[g]), .wea_A(wea_A[g]), .wea_B(wea_B[g]),
      .dout_A(dout_A[g]), .dout_B(dout_B[g]), .cur_op(cur_op[g]),
      .busy(busy[g]), .op_done(op_done[g]), .cmd_err(cmd_err[g])
    );

    // BRAM model with g+1 cycles of read latency
    logic [7:0] mem_a [N_VEC];
    logic [7:0] mem_b [N_VEC];
    logic [7:0] pa [g+1];
    logic [7:0] pb [g+1];
    always @(posedge clk) begin
      if (wea_A[g]) mem_a[addr[g]] <= din[g];
      if (wea_B[g]) mem_b[addr[g]] <= din[g];
      pa[0] <= mem_a[addr[g]];
      pb[0] <= mem_b[addr[g]];
      for (int i = 1; i <= g; i++) begin
        pa[i] <= pa[i-1];
        pb[i] <= pb[i-1];
      end
    end
    assign dout_A[g] = pa[g];
    assign dout_B[g] = pb[g];

    // uart_tx model: busy for 10 cycles after each tx_start
    int tx_cnt;
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n)           tx_cnt <= 0;
      else if (tx_start[g]) tx_cnt <= 10;
      else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
    end
    assign tx_busy[g] = (tx_cnt != 0);
  end

  // Reference model and scoreboard queues (shared; each copy has its own read pointer)
  logic [7:0]     ref_a [N_VEC];
  logic [7:0]     ref_b [N_VEC];
  logic [WRW-1:0] exp_wr [$];   // {is_B, addr, data}
  logic [7:0]     exp_tx [$];
  logic [1:0]     exp_ev [$];   // {op_done, cmd_err}
  int p_wr [NI];
  int p_tx [NI];
  int p_ev [NI];
  int errors;
  int checks;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit all_drained();
    for (int k = 0; k < NI; k++) begin
      if (p_wr[k] != exp_wr.size() || p_tx[k] != exp_tx.size() || p_ev[k] != exp_ev.size())
        return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic monitor();
    forever begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        if (!rst_n) begin
          check($sformatf("reset_outputs_zero[%0d]", k),
                int'(|{tx_data[k], tx_start[k], addr[k], din[k], wea_A[k], wea_B[k],
                       cur_op[k], busy[k], op_done[k], cmd_err[k]}), 0);
          p_wr[k] = exp_wr.size();
          p_tx[k] = exp_tx.size();
          p_ev[k] = exp_ev.size();
        end else begin
          if (wea_A[k] || wea_B[k]) begin
            check($sformatf("wea_exclusive[%0d]", k), int'(wea_A[k] & wea_B[k]), 0);
            check($sformatf("wr_expected[%0d]", k), int'(p_wr[k] < exp_wr.size()), 1);
            if (p_wr[k] < exp_wr.size()) begin
              check($sformatf("wr_bank_addr_data[%0d]", k),
                    int'({wea_B[k], addr[k], din[k]}), int'(exp_wr[p_wr[k]]));
              p_wr[k]++;
            end
          end
          if (tx_start[k]) begin
            check($sformatf("tx_expected[%0d]", k), int'(p_tx[k] < exp_tx.size()), 1);
            if (p_tx[k] < exp_tx.size()) begin
              check($sformatf("tx_data[%0d]", k), int'(tx_data[k]), int'(exp_tx[p_tx[k]]));
              p_tx[k]++;
            end
          end
          if (op_done[k] || cmd_err[k]) begin
            check($sformatf("ev_expected[%0d]", k), int'(p_ev[k] < exp_ev.size()), 1);
            if (p_ev[k] < exp_ev.size()) begin
              check($sformatf("done_err_event[%0d]", k),
                    int'({op_done[k], cmd_err[k]}), int'(exp_ev[p_ev[k]]));
              p_ev[k]++;
            end
          end
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge clk);
    #1 rx_data = b;
    rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  // Opcode byte; for legal opcodes also confirm decode right after acceptance.
  task automatic send_cmd(input logic [7:0] op);
    send_byte(op, 0);
    if (op >= OP_WA && op <= OP_RB) begin
      for (int k = 0; k < NI; k++) begin
        check($sformatf("cur_op_after_cmd[%0d]", k), int'(cur_op[k]), int'(op));
        check($sformatf("busy_after_cmd[%0d]", k), int'(busy[k]), 1);
      end
    end
  endtask

  task automatic drain(input string name, input int bound);
    int n = 0;
    while (!all_drained() && n < bound) begin
      @(posedge clk);
      n++;
    end
    check({name, "_drained"}, int'(all_drained()), 1);
    repeat (3) @(posedge clk);
  endtask

  // Payload for a write; mode 0: i%256, 1: random, 2: i%256 ^ 0xA5.
  task automatic write_vec(input logic is_b, input int count, input int mode, input bit last_tight);
    logic [7:0] b;
    for (int j = 0; j < count; j++) begin
      if (mode == 0)      b = 8'(j);
      else if (mode == 1) b = 8'($urandom_range(0, 255));
      else                b = 8'(j) ^ 8'hA5;
      if (is_b) ref_b[j] = b;
      else      ref_a[j] = b;
      exp_wr.push_back({is_b, AW'(j), b});
      if (mode == 0)
        send_byte(b, (last_tight && j == count - 1) ? 0 : 3);
      else
        send_byte(b, (last_tight && j == count - 1) ? 0 : $urandom_range(0, 3));
    end
  endtask

  task automatic push_read(input logic is_b);
    for (int j = 0; j < N_VEC; j++) exp_tx.push_back(is_b ? ref_b[j] : ref_a[j]);
    exp_ev.push_back(2'b10);
  endtask

  initial begin
    int n;
    int base;
    logic [7:0] bad;
    rst_n = 1'b0;
    rx_data = 8'h00;
    rx_ready = 1'b0;
    errors = 0;
    checks = 0;
    for (int k = 0; k < NI; k++) begin
      p_wr[k] = 0; p_tx[k] = 0; p_ev[k] = 0;
    end
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Write A with i%256, gap 3
    exp_ev.push_back(2'b10);
    send_cmd(OP_WA);
    write_vec(1'b0, N_VEC, 0, 1'b0);
    drain("write_a", 2000);

    // Write B random, then a read B command the cycle after op_done
    exp_ev.push_back(2'b10);
    send_cmd(OP_WB);
    write_vec(1'b1, N_VEC, 1, 1'b1);
    n = 0;
    while (!op_done[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("write_b_op_done_seen", int'(op_done[0]), 1);
    push_read(1'b1);
    send_cmd(OP_RB);
    drain("read_b", 30000);

    // Illegal opcodes: one cmd_err each, never busy
    for (int i = 0; i < 4; i++) begin
      if (i == 0)      bad = 8'h7F;
      else if (i == 1) bad = 8'h00;
      else             bad = 8'($urandom_range(5, 255));
      exp_ev.push_back(2'b01);
      send_cmd(bad);
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        check("busy_after_illegal", int'(busy), 0);
      end
      drain("illegal", 20);
    end

    // Partial write then silence: timeout abort, then a fresh full write at addr 0
    exp_ev.push_back(2'b01);
    send_cmd(OP_WA);
    write_vec(1'b0, 5, 1, 1'b0);
    drain("timeout", TMO * 3);
    exp_ev.push_back(2'b10);
    send_cmd(OP_WA);
    write_vec(1'b0, N_VEC, 2, 1'b0);
    drain("write_a_after_timeout", 8000);

    // Read A, reset near element 500, then a full read A with stray rx bytes
    push_read(1'b0);
    base = p_tx[0];
    send_cmd(OP_RA);
    n = 0;
    while ((p_tx[0] - base) < 500 && n < 20000) begin
      @(posedge clk);
      n++;
    end
    check("read_reached_500", int'((p_tx[0] - base) >= 500), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    push_read(1'b0);
    send_cmd(OP_RA);
    repeat (200) @(posedge clk);
    #1 rx_data = OP_WA;
    rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
    repeat (300) @(posedge clk);
    #1 rx_data = 8'h7F;
    rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
    drain("read_a_with_stray_rx", 30000);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("idle_after_read[%0d]", k), int'({busy[k], cur_op[k]}), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
